dmem_mmio: RTL

- Data-side memory stage directly downstream of the ARMV4 single-cycle core.
- Consumes the core's MemWrite, ALUResult (byte address) and WriteData, and returns ReadData in the same cycle.
- Maps a word RAM plus a small memory-mapped peripheral window: a free-running prescaled timer with compare/interrupt, and a GPIO output register.

---
 rtl/dmem_mmio_if.sv | 22 ++
 rtl/dmem_mmio.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_if.sv
// Core-to-data-memory bus: store strobe, byte address and store data out, load data back.
// Zero latency: ReadData is combinational from the address; no backpressure.
interface dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output ALUResult,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  ALUResult,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data memory stage: word RAM plus timer/GPIO MMIO window; same-cycle loads, stores on the edge, never stalls.
// Define ALIGN_CHECK_EN to suppress misaligned stores and flag them in STATUS bit1.
module dmem_mmio #(
    parameter int RAM_WORDS = 256,
    parameter int PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

    localparam logic [7:0] OFF_CNT  = 8'd0;
    localparam logic [7:0] OFF_CMP  = 8'd1;
    localparam logic [7:0] OFF_CTRL = 8'd2;
    localparam logic [7:0] OFF_STAT = 8'd3;
    localparam logic [7:0] OFF_GPIO = 8'd4;

    logic [31:0]   mem [2**AW];
    logic [AW-1:0] ram_idx;

    logic          hi_zero;
    logic          sel_ram;
    logic          sel_reg;
    logic [7:0]    reg_off;
    logic          store_en;
    logic          wr_ram;
    logic          wr_reg;

    logic [PW-1:0] psc;
    logic [31:0]   cnt;
    logic [31:0]   cmp;
    logic [2:0]    ctrl;
    logic          match;
    logic [31:0]   gpio;
    logic          tick;
    logic          cnt_hit;
    logic [31:0]   status;
    logic          irq_src;
    logic [31:0]   rdata;

    // Bits [1:0] never take part in the word index; indices past RAM_WORDS wrap.
    assign ram_idx = (RAM_WORDS > 1) ? bus.ALUResult[2 +: AW] : '0;
    assign hi_zero = (bus.ALUResult[31:11] == 21'd0);
    assign sel_ram = hi_zero & ~bus.ALUResult[10];
    assign sel_reg = hi_zero &  bus.ALUResult[10];
    assign reg_off = bus.ALUResult[9:2];

`ifdef ALIGN_CHECK_EN
    logic misaligned;
    logic align_err;

    assign misaligned = bus.MemWrite & (bus.ALUResult[1:0] != 2'b00);
    assign store_en   = bus.MemWrite & ~misaligned;
    assign status     = {30'd0, align_err, match};
    assign irq_src    = match | align_err;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^bus.ALUResult[1:0];
    assign store_en        = bus.MemWrite;
    assign status          = {31'd0, match};
    assign irq_src         = match;
`endif

    assign wr_ram  = store_en & sel_ram;
    assign wr_reg  = store_en & sel_reg;
    assign tick    = ctrl[0] & (psc == PSC_LAST);
    assign cnt_hit = tick & (cnt == cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            psc   <= '0;
            cnt   <= '0;
            cmp   <= '1;
            ctrl  <= '0;
            match <= 1'b0;
            gpio  <= '0;
`ifdef ALIGN_CHECK_EN
            align_err <= 1'b0;
`endif
        end else begin
            if (!ctrl[0] || tick) begin
                psc <= '0;
            end else begin
                psc <= psc + 1'b1;
            end

            if (tick) begin
                cnt <= (cnt_hit && ctrl[1]) ? 32'd0 : cnt + 32'd1;
            end
            // A software write to the counter overrides the same-cycle tick.
            if (wr_reg && reg_off == OFF_CNT) begin
                cnt <= bus.WriteData;
            end
            if (wr_reg && reg_off == OFF_CMP) begin
                cmp <= bus.WriteData;
            end
            if (wr_reg && reg_off == OFF_CTRL) begin
                ctrl <= bus.WriteData[2:0];
            end
            if (wr_reg && reg_off == OFF_GPIO) begin
                gpio <= bus.WriteData;
            end

            // Clear first so a coincident set wins.
            if (wr_reg && reg_off == OFF_STAT && bus.WriteData[0]) begin
                match <= 1'b0;
            end
            if (cnt_hit) begin
                match <= 1'b1;
            end
`ifdef ALIGN_CHECK_EN
            if (wr_reg && reg_off == OFF_STAT && bus.WriteData[1]) begin
                align_err <= 1'b0;
            end
            if (misaligned) begin
                align_err <= 1'b1;
            end
`endif
        end
    end

    // RAM has no reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[ram_idx] <= bus.WriteData;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel_ram) begin
            rdata = mem[ram_idx];
        end else if (sel_reg) begin
            case (reg_off)
                OFF_CNT:  rdata = cnt;
                OFF_CMP:  rdata = cmp;
                OFF_CTRL: rdata = {29'd0, ctrl};
                OFF_STAT: rdata = status;
                OFF_GPIO: rdata = gpio;
                default:  rdata = 32'd0;
            endcase
        end
    end

    assign bus.ReadData = rdata;
    assign gpio_out     = gpio;
    assign timer_irq    = irq_src & ctrl[2];

endmodule
